// File: rtl/mem_ctrl.sv
// -----------------------------------------------------------------------------
// mem_ctrl -- single-port 64-bit word memory behind a req/rdy handshake.
//
// A request is accepted in IDLE. A write commits to the array and a read
// captures the addressed word into the rdata register, both on that same
// edge. The FSM then walks WAIT (LATENCY-1 cycles, skipped for LATENCY=1),
// RESP (one-cycle rdy pulse) and GAP, where req is ignored for one cycle,
// before it returns to IDLE.
//
// Parameters
//   DEPTH_LOG2 : log2 of the number of 64-bit words (default 10)
//   LATENCY    : cycles from acceptance to rdy, 1..15 (default 2)
//
// Ports
//   clk    in   1  clock, rising edge
//   reset  in   1  synchronous, active-high reset
//   addr   in  64  byte address; addr[DEPTH_LOG2+2:3] selects the word
//   wdata  in  64  write data
//   rdata  out 64  read data, held until the next accepted read
//   req    in   1  request, held by the master until rdy
//   wr     in   1  1 = write, 0 = read
//   rdy    out  1  single-cycle completion pulse
//   busy   out  1  high whenever the FSM is not in IDLE
//   err    out  1  out-of-range completion flag, valid with rdy
//
// Optional feature: define MEM_CTRL_RANGE_CHECK_EN to flag addresses with
// any bit set above the array as out-of-range. Such a write is dropped, such
// a read returns 0, and err is raised in the RESP cycle. Timing is the same.
// Without the macro, upper address bits alias onto the array and err is 0.
// -----------------------------------------------------------------------------
module mem_ctrl #(
    parameter int DEPTH_LOG2 = 10,
    parameter int LATENCY    = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [63:0] addr,
    input  logic [63:0] wdata,
    output logic [63:0] rdata,
    input  logic        req,
    input  logic        wr,
    output logic        rdy,
    output logic        busy,
    output logic        err
);

    localparam int         DEPTH    = 1 << DEPTH_LOG2;
    localparam logic [3:0] CNT_LOAD = 4'(LATENCY - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2,
        GAP  = 2'd3
    } state_t;

    state_t      state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;
    logic        oor_q, oor_d;        // accepted request was out of range
    logic [63:0] rdata_q;

    logic [63:0] mem [DEPTH];

    logic [DEPTH_LOG2-1:0] index;
    logic                  oor;
    logic                  accept;

    assign index  = addr[DEPTH_LOG2+2:3];
    assign accept = (state_q == IDLE) && req;

`ifdef MEM_CTRL_RANGE_CHECK_EN
    assign oor = |addr[63:DEPTH_LOG2+3];
    // Byte-lane bits never select anything.
    logic unused_addr_bits;
    assign unused_addr_bits = ^addr[2:0];
`else
    // No range check: upper bits alias onto the array.
    assign oor = 1'b0;
    logic unused_addr_bits;
    assign unused_addr_bits = ^{addr[63:DEPTH_LOG2+3], addr[2:0]};
`endif

    // Next-state logic
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        oor_d   = oor_q;
        case (state_q)
            IDLE: begin
                if (req) begin
                    cnt_d   = CNT_LOAD;
                    oor_d   = oor;
                    state_d = (LATENCY == 1) ? RESP : WAIT;
                end
            end
            WAIT: begin
                cnt_d = cnt_q - 4'd1;
                if (cnt_q == 4'd1) begin
                    state_d = RESP;
                end
            end
            RESP: begin
                state_d = GAP;
            end
            GAP: begin
                // req is ignored here while the upstream arbiter re-selects.
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            cnt_q   <= 4'd0;
            oor_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            oor_q   <= oor_d;
        end
    end

    // Array write port. The contents are deliberately not reset.
    always_ff @(posedge clk) begin
        if (!reset && accept && wr && !oor) begin
            mem[index] <= wdata;
        end
    end

    // Registered read port. Only an accepted read reloads it, so rdata
    // stays put across writes and across the RESP/GAP/IDLE cycles.
    always_ff @(posedge clk) begin
        if (reset) begin
            rdata_q <= 64'd0;
        end else if (accept && !wr) begin
            rdata_q <= oor ? 64'd0 : mem[index];
        end
    end

    assign rdata = rdata_q;
    assign rdy   = (state_q == RESP);
    assign busy  = (state_q != IDLE);
    assign err   = (state_q == RESP) && oor_q;

endmodule

// File: tb/tb_mem_ctrl.sv
// -----------------------------------------------------------------------------
// tb_mem_ctrl -- directed self-checking bench for mem_ctrl.
// u0: DEPTH_LOG2=4, LATENCY=2.  u1: DEPTH_LOG2=4, LATENCY=1.
// Inputs are driven 1 time unit after a rising edge; outputs are sampled then.
// -----------------------------------------------------------------------------
module tb_mem_ctrl;

    logic        clk;
    logic        reset;

    logic [63:0] addr0, wdata0, rdata0;
    logic        req0, wr0, rdy0, busy0, err0;

    logic [63:0] addr1, wdata1, rdata1;
    logic        req1, wr1, rdy1, busy1, err1;

    int total;
    int bad;

    localparam logic [63:0] D_31  = 64'h1122334455667788;
    localparam logic [63:0] D_A0  = 64'h00000000A0A0A0A0;
    localparam logic [63:0] D_B0  = 64'h00000000B0B0B0B0;
    localparam logic [63:0] D_RST = 64'hDEADBEEF00C0FFEE;
    localparam logic [63:0] D_L1  = 64'h5555AAAA5555AAAA;

    mem_ctrl #(.DEPTH_LOG2(4), .LATENCY(2)) u0 (
        .clk   (clk),
        .reset (reset),
        .addr  (addr0),
        .wdata (wdata0),
        .rdata (rdata0),
        .req   (req0),
        .wr    (wr0),
        .rdy   (rdy0),
        .busy  (busy0),
        .err   (err0)
    );

    mem_ctrl #(.DEPTH_LOG2(4), .LATENCY(1)) u1 (
        .clk   (clk),
        .reset (reset),
        .addr  (addr1),
        .wdata (wdata1),
        .rdata (rdata1),
        .req   (req1),
        .wr    (wr1),
        .rdy   (rdy1),
        .busy  (busy1),
        .err   (err1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One complete transaction on u0, started from IDLE. The inputs are
    // scrambled right after acceptance; the block must ignore them.
    task automatic txn0(input string tag, input bit w, input logic [63:0] a,
                        input logic [63:0] d, input logic [63:0] exp_rd,
                        input bit exp_err);
        int n;
        req0 = 1'b1; wr0 = w; addr0 = a; wdata0 = d;
        tick();
        req0 = 1'b0; wr0 = ~w; addr0 = ~a; wdata0 = ~d;
        n = 1;
        while (rdy0 !== 1'b1 && n < 20) begin
            tick();
            n++;
        end
        chk({tag, " latency"}, 64'(n), 64'd2);
        chk({tag, " rdata"}, rdata0, exp_rd);
        chk({tag, " err"}, 64'(err0), 64'(exp_err));
        tick();
        chk({tag, " gap rdy"}, 64'(rdy0), 64'd0);
        chk({tag, " gap busy"}, 64'(busy0), 64'd1);
        chk({tag, " gap err"}, 64'(err0), 64'd0);
        tick();
        chk({tag, " idle busy"}, 64'(busy0), 64'd0);
        chk({tag, " rdata hold"}, rdata0, exp_rd);
        $display("txn %s: wr=%0d addr=%h rdata=%h err=%0d latency=%0d",
                 tag, w, a, rdata0, exp_err, n);
    endtask

    logic [63:0] acc_addr;
    int          last_acc;
    int          nacc;
    bit          prev_busy;
    bit          prev_rdy;

    initial begin
        total = 0;
        bad   = 0;
        reset = 1'b1;
        req0 = 1'b0; wr0 = 1'b0; addr0 = '0; wdata0 = '0;
        req1 = 1'b0; wr1 = 1'b0; addr1 = '0; wdata1 = '0;
        acc_addr = '0;
        repeat (2) tick();

        // Reset state
        chk("reset rdy",   64'(rdy0),  64'd0);
        chk("reset busy",  64'(busy0), 64'd0);
        chk("reset err",   64'(err0),  64'd0);
        chk("reset rdata", rdata0,     64'd0);
        chk("reset u1 busy", 64'(busy1), 64'd0);
        reset = 1'b0;
        tick();
        $display("txn reset: done");

        // Write then read back the same word; the write leaves rdata at 0.
        txn0("w18", 1'b1, 64'h18, D_31, 64'd0, 1'b0);
        txn0("r18", 1'b0, 64'h18, 64'd0, D_31, 1'b0);

        // Seed words 0 and 1 for the back-to-back test.
        txn0("w00", 1'b1, 64'h00, D_A0, D_31, 1'b0);
        txn0("w08", 1'b1, 64'h08, D_B0, D_31, 1'b0);

        // req held high, reads alternating 0x00 / 0x08.
        prev_busy = 1'b0; prev_rdy = 1'b0; last_acc = 0; nacc = 0;
        req0 = 1'b1; wr0 = 1'b0; addr0 = 64'h00;
        for (int c = 1; c <= 16; c++) begin
            tick();
            if (busy0 && !prev_busy) begin
                if (nacc > 0) chk("b2b spacing", 64'(c - last_acc), 64'd4);
                last_acc = c;
                nacc++;
                acc_addr = addr0;
                addr0 = addr0 ^ 64'h8;
                $display("txn b2b: accept cycle=%0d addr=%h", c, acc_addr);
            end
            if (rdy0) begin
                chk("b2b rdy single", 64'(prev_rdy), 64'd0);
                chk("b2b rdata", rdata0, (acc_addr == 64'h0) ? D_A0 : D_B0);
            end
            prev_busy = busy0;
            prev_rdy  = rdy0;
        end
        req0 = 1'b0;
        chk("b2b accept count", 64'(nacc), 64'd4);

        // Reset during WAIT of a write: aborted, but the write is already in.
        req0 = 1'b1; wr0 = 1'b1; addr0 = 64'h20; wdata0 = D_RST;
        tick();
        chk("rstmid wait busy", 64'(busy0), 64'd1);
        req0 = 1'b0;
        reset = 1'b1;
        tick();
        chk("rstmid rdy",   64'(rdy0),  64'd0);
        chk("rstmid busy",  64'(busy0), 64'd0);
        chk("rstmid rdata", rdata0,     64'd0);
        reset = 1'b0;
        tick();
        chk("rstmid after rdy",  64'(rdy0),  64'd0);
        chk("rstmid after busy", 64'(busy0), 64'd0);
        $display("txn rstmid: reset in WAIT of write 0x20");
        txn0("r20", 1'b0, 64'h20, 64'd0, D_RST, 1'b0);

        // LATENCY=1 instance: rdy right after acceptance, busy for 2 cycles.
        req1 = 1'b1; wr1 = 1'b1; addr1 = 64'h10; wdata1 = D_L1;
        tick();
        req1 = 1'b0;
        chk("l1 w rdy",  64'(rdy1),  64'd1);
        chk("l1 w busy", 64'(busy1), 64'd1);
        tick();
        chk("l1 w gap rdy",  64'(rdy1),  64'd0);
        chk("l1 w gap busy", 64'(busy1), 64'd1);
        tick();
        chk("l1 w idle busy", 64'(busy1), 64'd0);
        $display("txn l1 w10: data=%h", D_L1);
        req1 = 1'b1; wr1 = 1'b0; addr1 = 64'h10;
        tick();
        req1 = 1'b0;
        chk("l1 r rdy",   64'(rdy1),  64'd1);
        chk("l1 r busy",  64'(busy1), 64'd1);
        chk("l1 r rdata", rdata1,     D_L1);
        tick();
        chk("l1 r gap rdy",  64'(rdy1),  64'd0);
        chk("l1 r gap busy", 64'(busy1), 64'd1);
        tick();
        chk("l1 r idle busy", 64'(busy1), 64'd0);
        $display("txn l1 r10: rdata=%h", rdata1);

`ifdef MEM_CTRL_RANGE_CHECK_EN
        // Out-of-range write is dropped and flagged; word 0 keeps D_A0.
        txn0("w80 oor", 1'b1, 64'h80, 64'hFF, D_RST, 1'b1);
        txn0("r00",     1'b0, 64'h00, 64'd0,  D_A0,  1'b0);
        txn0("r80 oor", 1'b0, 64'h80, 64'd0,  64'd0, 1'b1);
`else
        // Upper address bits alias: 0x80 lands on word 0.
        txn0("w80 alias", 1'b1, 64'h80, 64'hAB, D_RST, 1'b0);
        txn0("r00",       1'b0, 64'h00, 64'd0,  64'hAB, 1'b0);
        txn0("r80 alias", 1'b0, 64'h80, 64'd0,  64'hAB, 1'b0);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
